// File: rtl/div_seq_unit.sv
// div_seq_unit: sequential signed 32-bit restoring divider, quotient on lo_out, remainder on hi_out.
// Optional DIV_EARLY_EXIT_EN: a request with |a| < |b| completes without the 32-step run.
module div_seq_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        div_start,
  output logic        div_stop,
  output logic        div_zero,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [2:0] {IDLE, RUN, FIX, DONE, ZERO} state_t;
  state_t state, state_nxt;

  logic [W-1:0]  quo, dvs, a_mag, b_mag;
  logic [W:0]    rem, shifted, diff;
  logic [CW-1:0] cnt;
  logic          sign_q, sign_r;
  logic          stop_nxt, zero_nxt, early;

  // -2^31 maps to the unsigned magnitude 0x80000000
  assign a_mag = a_in[W-1] ? W'(-a_in) : a_in;
  assign b_mag = b_in[W-1] ? W'(-b_in) : b_in;

`ifdef DIV_EARLY_EXIT_EN
  assign early = (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  // One restoring step: shift {rem, quo} left and trial-subtract the divisor
  assign shifted = (W+1)'({rem, quo[W-1]});
  assign diff    = shifted - {1'b0, dvs};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      div_stop <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_stop <= stop_nxt;
      div_zero <= zero_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stop_nxt  = 1'b0;
    zero_nxt  = 1'b0;
    case (state)
      IDLE: if (div_start) state_nxt = (b_in == '0) ? ZERO : RUN;
      RUN:  if (cnt == CW'(W-1)) state_nxt = FIX;
      FIX: begin
        state_nxt = DONE;
        stop_nxt  = 1'b1;
      end
      DONE: state_nxt = IDLE;
      ZERO: begin
        state_nxt = IDLE;
        zero_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo    <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        IDLE: if (div_start && (b_in != '0)) begin
          sign_q <= a_in[W-1] ^ b_in[W-1];
          sign_r <= a_in[W-1];
          dvs    <= b_mag;
          if (early) begin
            // Preload so the single final step yields quo=0, rem=|a|
            rem <= {2'b00, a_mag[W-1:1]};
            quo <= {a_mag[0], {(W-1){1'b0}}};
            cnt <= CW'(W-1);
          end else begin
            rem <= '0;
            quo <= a_mag;
            cnt <= '0;
          end
        end
        RUN: begin
          if (!diff[W]) begin
            rem <= diff;
            quo <= {quo[W-2:0], 1'b1};
          end else begin
            rem <= shifted;
            quo <= {quo[W-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          lo_out <= sign_q ? W'(-quo) : quo;
          hi_out <= sign_r ? W'(-rem[W-1:0]) : rem[W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_unit.sv
// Bench for div_seq_unit: table vectors, random vectors against a signed-division model,
// plus busy-start and mid-run reset sequences; expected results flow through a scoreboard queue.
`timescale 1ns/1ps
module tb_div_seq_unit;
  logic        clk = 1'b0;
  logic        reset, div_start, div_stop, div_zero;
  logic [31:0] a_in, b_in, hi_out, lo_out;

  always #5 clk = ~clk;

  div_seq_unit dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .div_start(div_start),
    .div_stop(div_stop), .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out)
  );

  typedef struct { logic [31:0] a, b, lo, hi; bit zero; } vec_t;
  typedef struct { logic [31:0] lo, hi; bit zero; int lat; } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] prev_lo = '0;
  logic [31:0] prev_hi = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Cycles from the sampling edge E0 to the edge where the pulse rises
  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input bit zero);
    logic [31:0] am, bm;
    am = a[31] ? -a : a;
    bm = b[31] ? -b : b;
    if (zero) return 1;
`ifdef DIV_EARLY_EXIT_EN
    if (am < bm) return 2;
`endif
    if (am == bm) return 33;
    return 33;
  endfunction

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] elo,
                         input logic [31:0] ehi, input bit ez, input int poke, input string tag);
    exp_t e, x;
    int   cyc;
    bit   seen;
    e.zero = ez;
    e.lat  = exp_lat(a, b, ez);
    e.lo   = ez ? prev_lo : elo;
    e.hi   = ez ? prev_hi : ehi;
    @(negedge clk);
    a_in = a; b_in = b; div_start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    div_start = 1'b0;
    a_in = $urandom;
    b_in = $urandom | 32'd1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == poke) div_start = 1'b1;
      if (cyc == poke + 1) div_start = 1'b0;
      if (div_stop || div_zero) begin
        seen = 1'b1;
        x = sb.pop_front();
        chk({tag, " latency"}, 32'(cyc), 32'(x.lat));
        chk({tag, " div_zero"}, 32'(div_zero), 32'(x.zero));
        chk({tag, " div_stop"}, 32'(div_stop), 32'(!x.zero));
        chk({tag, " lo_out"}, lo_out, x.lo);
        chk({tag, " hi_out"}, hi_out, x.hi);
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: no pulse within 60 cycles, one required", tag);
      void'(sb.pop_front());
    end else begin
      @(posedge clk); #1;
      chk({tag, " pulse width"}, 32'({div_stop, div_zero}), 32'(0));
    end
    if (!ez) begin
      prev_lo = elo;
      prev_hi = ehi;
    end
  endtask

  initial begin
    vec_t        tbl[13];
    logic [31:0] ra, rb, rq, rr;
    bit          seen;

    tbl[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1]  = '{32'd5,          32'd0,          32'd0,          32'd0,          1'b1};
    tbl[2]  = '{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    tbl[3]  = '{32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    tbl[4]  = '{32'd14,         32'd2,          32'd7,          32'd0,          1'b0};
    tbl[5]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    tbl[6]  = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    tbl[7]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    tbl[8]  = '{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0};
    tbl[9]  = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1'b0};
    tbl[10] = '{32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          32'h7FFF_FFFF,  1'b0};
    tbl[11] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    tbl[12] = '{32'd0,          32'd0,          32'd0,          32'd0,          1'b1};

    reset = 1'b1; div_start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset div_stop", 32'(div_stop), 32'(0));
    chk("reset div_zero", 32'(div_zero), 32'(0));
    chk("reset lo_out", lo_out, 32'd0);
    chk("reset hi_out", hi_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++)
      run_div(tbl[i].a, tbl[i].b, tbl[i].lo, tbl[i].hi, tbl[i].zero, 0, $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 0) rb = 32'd1;
      if ($urandom_range(0, 1) == 1) ra = -ra;
      if ($urandom_range(0, 1) == 1) rb = -rb;
      model(ra, rb, rq, rr);
      run_div(ra, rb, rq, rr, 1'b0, 0, $sformatf("rnd%0d", i));
    end

    // Start pulse during RUN must be ignored; the next idle request completes normally
    run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 5, "busy");
    run_div(32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 0, "after_busy");

    // Reset at E10 of 1000/3 aborts with cleared outputs and no pulse
    @(negedge clk);
    a_in = 32'd1000; b_in = 32'd3; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort lo_out", lo_out, 32'd0);
    chk("abort hi_out", hi_out, 32'd0);
    chk("abort pulses", 32'({div_stop, div_zero}), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    prev_lo = '0;
    prev_hi = '0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (div_stop || div_zero) seen = 1'b1;
    end
    chk("abort no pulse", 32'(seen), 32'(0));
    chk("abort lo hold", lo_out, 32'd0);
    run_div(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 0, "post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
